divisor_secuencial: RTL and testbench

DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

---
 rtl/divisor_pkg.sv | 28 ++
 rtl/uc_div.sv | 87 ++++++++
 rtl/divisor_secuencial.sv | 122 ++++++++++++
 tb/tb_divisor_secuencial.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// rtl/divisor_pkg.sv - shared widths, FSM encoding and magnitude helpers for the sequential divider
package divisor_pkg;

    localparam int DW     = 6;          // dividend / quotient width
    localparam int VW     = 3;          // divisor / remainder width
    localparam int RW     = VW + 1;     // partial remainder width (holds shifted value before subtract)
    localparam int N_ITER = 6;          // one quotient bit per iteration
    localparam int CW     = 3;          // iteration counter width, counts 0..N_ITER-1

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Unsigned magnitude of a signed dividend; the most negative value maps to 2**(DW-1)
    function automatic logic [DW-1:0] mag_dvd(input logic [DW-1:0] v);
        return v[DW-1] ? -v : v;
    endfunction

    // Unsigned magnitude of a signed divisor; the most negative value maps to 2**(VW-1)
    function automatic logic [VW-1:0] mag_dvs(input logic [VW-1:0] v);
        return v[VW-1] ? -v : v;
    endfunction

endpackage

// File: rtl/uc_div.sv
// rtl/uc_div.sv - control unit: FSM and iteration counter issuing datapath strobes
module uc_div
    import divisor_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inicio_i,
    input  logic div_zero_i,    // captured divisor is zero and early abort is enabled
    output logic capture_o,     // latch operands and clear flags this edge
    output logic load_o,        // form magnitudes and signs this edge
    output logic iter_o,        // shift and trial-subtract this edge
    output logic sign_o,        // apply signs and load results this edge
    output logic fin_o
);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            load_q;
    logic            iter_q;
    logic            sign_q;
    logic            fin_q;

    // Start is a level sampled only in IDLE, so capture depends on the live input
    assign capture_o = (state_q == ST_IDLE) && inicio_i;
    assign load_o    = load_q;
    assign iter_o    = iter_q;
    assign sign_o    = sign_q;
    assign fin_o     = fin_q;

    // Sequencing FSM; strobes are registered so each is high exactly while in its state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            iter_q  <= 1'b0;
            sign_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            iter_q <= 1'b0;
            sign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (inicio_i) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (div_zero_i) begin
                        state_q <= ST_DONE;
                        fin_q   <= 1'b1;
                    end else begin
                        state_q <= ST_ITER;
                        cnt_q   <= '0;
                        iter_q  <= 1'b1;
                    end
                end
                ST_ITER: begin
                    if (cnt_q == CW'(N_ITER - 1)) begin
                        state_q <= ST_SIGN;
                        sign_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + CW'(1);
                        iter_q <= 1'b1;
                    end
                end
                ST_SIGN: begin
                    state_q <= ST_DONE;
                    fin_q   <= 1'b1;
                end
                ST_DONE: begin
                    if (!inicio_i) begin
                        state_q <= ST_IDLE;
                        fin_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    fin_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - signed 6/3-bit restoring divider; DIV_ERR_EN enables div-by-zero abort and overflow flag
module divisor_secuencial
    import divisor_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] dividendo,
    input  logic [VW-1:0] divisor_op,
    input  logic          inicio,
    output logic [DW-1:0] cociente,
    output logic [VW-1:0] resto,
    output logic          Fin,
    output logic          err_div0,
    output logic          desbordamiento
);

    logic          capture_s, load_s, iter_s, sign_s, fin_s, div_zero_s;

    logic [DW-1:0] dvd_cap_q;
    logic [VW-1:0] dvs_cap_q;
    logic [DW-1:0] dvd_q;       // dividend magnitude shifting out, quotient bits shifting in
    logic [VW-1:0] dvs_mag_q;
    logic [RW-1:0] rem_q;
    logic          neg_quo_q;
    logic          neg_rem_q;
    logic [DW-1:0] cociente_q;
    logic [VW-1:0] resto_q;

    logic [RW:0]   trial_s;
    logic [RW-1:0] rem_shift_s;
    logic          fits_s;

    uc_div u_uc (
        .clk_i      (clk),
        .rst_ni     (reset),
        .inicio_i   (inicio),
        .div_zero_i (div_zero_s),
        .capture_o  (capture_s),
        .load_o     (load_s),
        .iter_o     (iter_s),
        .sign_o     (sign_s),
        .fin_o      (fin_s)
    );

    // Shifted partial remainder and one-bit-wider trial difference; the top bit is the borrow
    assign rem_shift_s = {rem_q[RW-2:0], dvd_q[DW-1]};
    assign trial_s     = {rem_q, dvd_q[DW-1]} - (RW+1)'(dvs_mag_q);
    assign fits_s      = ~trial_s[RW];

`ifdef DIV_ERR_EN
    logic err_q;
    logic ovf_q;

    assign div_zero_s = (dvs_cap_q == '0);

    // Error flags: cleared at every start, set on zero divisor at LOAD or positive 2**(DW-1) quotient at SIGN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (capture_s) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (load_s && div_zero_s) begin
            err_q <= 1'b1;
        end else if (sign_s) begin
            ovf_q <= ~neg_quo_q & dvd_q[DW-1];
        end
    end

    assign err_div0       = err_q;
    assign desbordamiento = ovf_q;
`else
    assign div_zero_s     = 1'b0;
    assign err_div0       = 1'b0;
    assign desbordamiento = 1'b0;
`endif

    // Datapath: operand capture, magnitude load, restoring iterations and signed result load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd_cap_q  <= '0;
            dvs_cap_q  <= '0;
            dvd_q      <= '0;
            dvs_mag_q  <= '0;
            rem_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            cociente_q <= '0;
            resto_q    <= '0;
        end else begin
            if (capture_s) begin
                dvd_cap_q <= dividendo;
                dvs_cap_q <= divisor_op;
            end
            if (load_s) begin
                dvd_q     <= mag_dvd(dvd_cap_q);
                dvs_mag_q <= mag_dvs(dvs_cap_q);
                neg_quo_q <= dvd_cap_q[DW-1] ^ dvs_cap_q[VW-1];
                neg_rem_q <= dvd_cap_q[DW-1];
                rem_q     <= '0;
                if (div_zero_s) begin
                    cociente_q <= '0;
                    resto_q    <= '0;
                end
            end
            if (iter_s) begin
                rem_q <= fits_s ? trial_s[RW-1:0] : rem_shift_s;
                dvd_q <= {dvd_q[DW-2:0], fits_s};
            end
            if (sign_s) begin
                cociente_q <= neg_quo_q ? -dvd_q : dvd_q;
                resto_q    <= neg_rem_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
            end
        end
    end

    assign cociente = cociente_q;
    assign resto    = resto_q;
    assign Fin      = fin_s;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - scoreboard bench for divisor_secuencial (DIV_ERR_EN-aware)
module tb_divisor_secuencial;

`ifdef DIV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       inicio = 1'b0;
    logic [5:0] dividendo = '0;
    logic [2:0] divisor_op = '0;
    logic [5:0] cociente;
    logic [2:0] resto;
    logic       Fin, err_div0, desbordamiento;

    typedef struct {
        logic [5:0] q;
        logic [2:0] r;
        bit         chk_qr;
        bit         err;
        bit         ovf;
        int         start;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   fin_prev = 1'b0;

    divisor_secuencial dut (
        .clk            (clk),
        .reset          (reset),
        .dividendo      (dividendo),
        .divisor_op     (divisor_op),
        .inicio         (inicio),
        .cociente       (cociente),
        .resto          (resto),
        .Fin            (Fin),
        .err_div0       (err_div0),
        .desbordamiento (desbordamiento)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Monitor: every rising Fin is matched against the oldest expected result
    always @(negedge clk) begin
        if (Fin && !fin_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_fin: got Fin=1 want no result pending");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_qr) begin
                    chk("cociente", int'(cociente), int'(e.q));
                    chk("resto", int'(resto), int'(e.r));
                end
                chk("err_div0", int'(err_div0), int'(e.err));
                chk("desbordamiento", int'(desbordamiento), int'(e.ovf));
                chk("latency", cyc - e.start, e.lat);
            end
        end
        fin_prev = Fin;
    end

    // Drive operands with inicio high now; the next rising edge is the start edge
    task automatic start_op(input logic [5:0] a, input logic [2:0] b, input logic [5:0] q,
                            input logic [2:0] r, input bit chk_qr, input bit err, input bit ovf,
                            input int lat);
        dividendo  = a;
        divisor_op = b;
        inicio     = 1'b1;
        sb.push_back('{q: q, r: r, chk_qr: chk_qr, err: err, ovf: ovf, start: cyc + 1, lat: lat});
    endtask

    task automatic wait_fin();
        int n = 0;
        while (!Fin && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!Fin) begin
            total++;
            bad++;
            $display("FAIL fin_timeout: got Fin=0 want Fin=1 within 30 cycles");
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic run_op(input logic [5:0] a, input logic [2:0] b, input logic [5:0] q,
                          input logic [2:0] r, input bit chk_qr, input bit err, input bit ovf,
                          input int lat, input bit hold);
        @(negedge clk);
        start_op(a, b, q, r, chk_qr, err, ovf, lat);
        if (!hold) begin
            @(negedge clk);
            inicio = 1'b0;
        end
        wait_fin();
        if (!hold) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cociente"}, int'(cociente), 0);
        chk({tag, "_resto"}, int'(resto), 0);
        chk({tag, "_fin"}, int'(Fin), 0);
        chk({tag, "_err"}, int'(err_div0), 0);
        chk({tag, "_ovf"}, int'(desbordamiento), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        run_op(6'b001101, 3'b011, 6'b000100, 3'b001, 1'b1, 1'b0, 1'b0, 8, 1'b0);   // 13/3
        run_op(6'b110011, 3'b011, 6'b111100, 3'b111, 1'b1, 1'b0, 1'b0, 8, 1'b0);   // -13/3
        run_op(6'b001101, 3'b101, 6'b111100, 3'b001, 1'b1, 1'b0, 1'b0, 8, 1'b0);   // 13/-3
        run_op(6'b100000, 3'b111, 6'b100000, 3'b000, 1'b1, 1'b0, ERR_EN, 8, 1'b0); // -32/-1
        run_op(6'b100000, 3'b001, 6'b100000, 3'b000, 1'b1, 1'b0, 1'b0, 8, 1'b0);   // -32/1
        run_op(6'b101010, 3'b100, 6'b000101, 3'b110, 1'b1, 1'b0, 1'b0, 8, 1'b0);   // -22/-4
`ifdef DIV_ERR_EN
        run_op(6'b000111, 3'b000, 6'b000000, 3'b000, 1'b1, 1'b1, 1'b0, 1, 1'b0);   // 7/0 abort
`else
        run_op(6'b000111, 3'b000, 6'b000000, 3'b000, 1'b0, 1'b0, 1'b0, 8, 1'b0);   // 7/0 unchecked value
`endif

        // Hold inicio high in DONE: result and Fin must stay put with no restart
        run_op(6'b100000, 3'b111, 6'b100000, 3'b000, 1'b1, 1'b0, ERR_EN, 8, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("hold_fin", int'(Fin), 1);
            chk("hold_cociente", int'(cociente), 6'b100000);
            chk("hold_ovf", int'(desbordamiento), int'(ERR_EN));
        end
        inicio = 1'b0;
        @(negedge clk);
        chk("drop_fin", int'(Fin), 0);
        start_op(6'b001101, 3'b011, 6'b000100, 3'b001, 1'b1, 1'b0, 1'b0, 8);
        @(negedge clk);
        chk("restart_err_clr", int'(err_div0), 0);
        chk("restart_ovf_clr", int'(desbordamiento), 0);
        wait_fin();
        inicio = 1'b0;
        @(negedge clk);
        chk("restart_drop_fin", int'(Fin), 0);

        // Reset pulsed during the third ITER cycle of an operation that must not complete
        @(negedge clk);
        dividendo  = 6'b010100;
        divisor_op = 3'b011;
        inicio     = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        chk_all_zero("midreset_hold");
        reset = 1'b1;

        run_op(6'b011111, 3'b100, 6'b111001, 3'b011, 1'b1, 1'b0, 1'b0, 8, 1'b0);   // 31/-4

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
